// File: rtl/rtc_field_editor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rtc_pkg : shared constants and types for the RTC field editor        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rtc_pkg;

    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 3;
    localparam int BTN_CENTER = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    localparam logic [3:0] MODE_EDIT = 4'b0101;
    localparam logic [3:0] MODE_RUN  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EDIT      = 2'd1,
        WAIT_EXIT = 2'd2
    } edit_fsm_t;

    function automatic int cursor_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_field_editor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rtc_field_editor_if : mode/button/counter bus of the field editor    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface rtc_field_editor_if #(
    parameter int NUM_FIELDS = 3,
    parameter int FIELD_W    = 6
);
    import rtc_pkg::*;

    localparam int CUR_W = cursor_width(NUM_FIELDS);

    logic [3:0]                    STATE;
    logic [4:0]                    BUTTONS;
    logic [NUM_FIELDS*FIELD_W-1:0] CLOCK_DATA;
    logic [NUM_FIELDS*FIELD_W-1:0] TIME_SETDATA;
    logic                          TIME_SET_FLAG;
    logic [NUM_FIELDS*FIELD_W-1:0] EDIT_DATA;
    logic [CUR_W-1:0]              CURSOR;
    logic                          EDITING;

    modport master (
        output STATE, BUTTONS, CLOCK_DATA,
        input  TIME_SETDATA, TIME_SET_FLAG, EDIT_DATA, CURSOR, EDITING
    );

    modport slave (
        input  STATE, BUTTONS, CLOCK_DATA,
        output TIME_SETDATA, TIME_SET_FLAG, EDIT_DATA, CURSOR, EDITING
    );

endinterface
`default_nettype wire

// File: rtl/rtc_field_editor_btn_repeat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_repeat : rising-edge step pulse with hold-to-repeat              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module btn_repeat #(
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  wire  CLK,
    input  wire  RESET,
    input  logic btn_i,
    output logic step_o
);

    localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    logic             btn_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rate_q, rate_d;

    // cnt_q holds cycles since the last step; rate_q marks the post-delay phase
    always_comb begin
        step_o = 1'b0;
        cnt_d  = cnt_q;
        rate_d = rate_q;
        if (!btn_i) begin
            cnt_d  = '0;
            rate_d = 1'b0;
        end else if (!btn_q) begin
            step_o = 1'b1;
            cnt_d  = CNT_W'(1);
            rate_d = 1'b0;
        end else if (!rate_q && (cnt_q == CNT_W'(REPEAT_DELAY))) begin
            step_o = 1'b1;
            cnt_d  = CNT_W'(1);
            rate_d = 1'b1;
        end else if (rate_q && (cnt_q == CNT_W'(REPEAT_RATE))) begin
            step_o = 1'b1;
            cnt_d  = CNT_W'(1);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            btn_q  <= 1'b0;
            cnt_q  <= '0;
            rate_q <= 1'b0;
        end else begin
            btn_q  <= btn_i;
            cnt_q  <= cnt_d;
            rate_q <= rate_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rtc_field_editor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rtc_field_editor : button-driven editor for a packed time/date word  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rtc_field_editor
    import rtc_pkg::*;
#(
    parameter int                            NUM_FIELDS   = 3,
    parameter int                            FIELD_W      = 6,
    parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MAX    = {6'd23, 6'd59, 6'd59},
    parameter logic [3:0]                    EDIT_STATE   = MODE_EDIT,
    parameter int                            REPEAT_DELAY = 500,
    parameter int                            REPEAT_RATE  = 100,
    parameter int                            TIMEOUT      = 30000
) (
    input wire                CLK,
    input wire                RESET,
    rtc_field_editor_if.slave bus
);

    localparam int DATA_W = NUM_FIELDS * FIELD_W;
    localparam int CUR_W  = cursor_width(NUM_FIELDS);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    generate
        if (NUM_FIELDS < 1 || FIELD_W < 1 || TIMEOUT < 1 ||
            REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
            $error("rtc_field_editor: invalid parameter set");
        end
    endgenerate

    edit_fsm_t         state_q, state_d;
    logic [3:0]        mode_prev_q;
    logic [4:0]        btn_q;
    logic              dn_blk_q;
    logic [DATA_W-1:0] work_q, work_d;
    logic [CUR_W-1:0]  cursor_q, cursor_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [DATA_W-1:0] setdata_q, setdata_d;
    logic              flag_q, flag_d;

    logic              in_mode, entry;
    logic [4:0]        rise;
    logic              up_step, dn_step, dn_lvl;
    logic [DATA_W-1:0] clamped;
    int                sel_base;
    logic [FIELD_W-1:0] sel_val, sel_max;

    assign in_mode  = (bus.STATE == EDIT_STATE);
    assign entry    = in_mode && (mode_prev_q != EDIT_STATE);
    assign rise     = bus.BUTTONS & ~btn_q;
    // DOWN stays blocked after an UP+DOWN overlap until DOWN itself is released
    assign dn_lvl   = bus.BUTTONS[BTN_DOWN] & ~bus.BUTTONS[BTN_UP] & ~dn_blk_q;
    assign sel_base = int'(cursor_q) * FIELD_W;
    assign sel_val  = work_q[sel_base +: FIELD_W];
    assign sel_max  = FIELD_MAX[sel_base +: FIELD_W];

    btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_rpt_up (
        .CLK    (CLK),
        .RESET  (RESET),
        .btn_i  (bus.BUTTONS[BTN_UP]),
        .step_o (up_step)
    );

    btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_rpt_dn (
        .CLK    (CLK),
        .RESET  (RESET),
        .btn_i  (dn_lvl),
        .step_o (dn_step)
    );

    always_comb begin
        clamped = bus.CLOCK_DATA;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (bus.CLOCK_DATA[i*FIELD_W +: FIELD_W] > FIELD_MAX[i*FIELD_W +: FIELD_W])
                clamped[i*FIELD_W +: FIELD_W] = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cursor_d  = cursor_q;
        to_d      = to_q;
        setdata_d = setdata_q;
        flag_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (entry) begin
                    state_d  = EDIT;
                    work_d   = clamped;
                    cursor_d = '0;
                    to_d     = '0;
                end
            end
            EDIT: begin
                if (!in_mode) begin
                    state_d = IDLE;
                end else if (rise[BTN_CENTER]) begin
                    setdata_d = work_q;
                    flag_d    = 1'b1;
                    state_d   = WAIT_EXIT;
                end else if (up_step) begin
                    work_d[sel_base +: FIELD_W] = (sel_val == sel_max) ? '0 : sel_val + 1'b1;
                    to_d = '0;
                end else if (dn_step) begin
                    work_d[sel_base +: FIELD_W] = (sel_val == '0) ? sel_max : sel_val - 1'b1;
                    to_d = '0;
                end else if (rise[BTN_LEFT]) begin
                    cursor_d = (cursor_q == CUR_W'(NUM_FIELDS - 1)) ? '0 : cursor_q + 1'b1;
                    to_d     = '0;
                end else if (rise[BTN_RIGHT]) begin
                    cursor_d = (cursor_q == '0) ? CUR_W'(NUM_FIELDS - 1) : cursor_q - 1'b1;
                    to_d     = '0;
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = WAIT_EXIT;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            WAIT_EXIT: begin
                if (!in_mode)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            mode_prev_q <= '0;
            btn_q       <= '0;
            dn_blk_q    <= 1'b0;
            work_q      <= '0;
            cursor_q    <= '0;
            to_q        <= '0;
            setdata_q   <= '0;
            flag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_prev_q <= bus.STATE;
            btn_q       <= bus.BUTTONS;
            dn_blk_q    <= bus.BUTTONS[BTN_DOWN] & (bus.BUTTONS[BTN_UP] | dn_blk_q);
            work_q      <= work_d;
            cursor_q    <= cursor_d;
            to_q        <= to_d;
            setdata_q   <= setdata_d;
            flag_q      <= flag_d;
        end
    end

    assign bus.TIME_SETDATA  = setdata_q;
    assign bus.TIME_SET_FLAG = flag_q;
    assign bus.EDIT_DATA     = work_q;
    assign bus.CURSOR        = cursor_q;
    assign bus.EDITING       = (state_q == EDIT);

endmodule
`default_nettype wire

// File: doc/rtc_field_editor.md
Name: rtc_field_editor

Overview:
- Button-driven editor for a packed multi-field time/date word. It is the parametrised successor of the fixed HH:MM:SS setup block.
- It captures the live counter value on entry to the edit mode, lets the user move a cursor and increment/decrement the selected field, and commits with a one-cycle load strobe to the counter.
- New over the previous generation: configurable field count, width and per-field maximum; auto-repeat on held UP/DOWN; inactivity timeout; a live edit-data view for the display.

Parameters:
- NUM_FIELDS, 3, number of fields; field 0 is least significant (seconds).
- FIELD_W, 6, bits per field.
- FIELD_MAX, {6'd23,6'd59,6'd59}, packed per-field maximum, NUM_FIELDS*FIELD_W bits.
- EDIT_STATE, 4'b0101, STATE code that enables editing.
- REPEAT_DELAY, 500, CLK cycles UP/DOWN must be held before the first auto-repeat step.
- REPEAT_RATE, 100, CLK cycles between subsequent auto-repeat steps.
- TIMEOUT, 30000, CLK cycles without a button event before the edit is aborted.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- STATE  in  4  top-level mode code.
- BUTTONS  in  5  debounced, CLK-synchronous levels: [4]=UP, [3]=DOWN, [2]=CENTER, [1]=LEFT, [0]=RIGHT.
- CLOCK_DATA  in  NUM_FIELDS*FIELD_W  live counter value.
- TIME_SETDATA  out  NUM_FIELDS*FIELD_W  value to load into the counter.
- TIME_SET_FLAG  out  1  one-CLK load strobe.
- EDIT_DATA  out  NUM_FIELDS*FIELD_W  working value (shown by the display while EDITING=1).
- CURSOR  out  max(1,$clog2(NUM_FIELDS))  selected field index.
- EDITING  out  1  high in the EDIT state.

Behaviour:
- Reset (asynchronous, RESET=1): all outputs 0; FSM in IDLE; button history 0; all counters 0.
- FSM states: IDLE, EDIT, WAIT_EXIT.
- IDLE -> EDIT: on the cycle STATE becomes EDIT_STATE (previous STATE was different).
  - Working register is loaded from CLOCK_DATA.
  - Any field greater than its FIELD_MAX is loaded as 0.
  - CURSOR set to 0; timeout counter cleared.
- Button events: rising edges only (BUTTONS & ~BUTTONS_q).
  - If several edges occur in one cycle, only one acts, priority CENTER > UP > DOWN > LEFT > RIGHT.
  - Response latency: an edge sampled at CLK edge k updates EDIT_DATA/CURSOR at edge k+1.
- EDIT actions:
  - UP: selected field +1; at FIELD_MAX it wraps to 0.
  - DOWN: selected field -1; at 0 it wraps to FIELD_MAX.
  - LEFT: CURSOR+1, wrapping NUM_FIELDS-1 -> 0.
  - RIGHT: CURSOR-1, wrapping 0 -> NUM_FIELDS-1.
  - Other fields are never modified; no carry or borrow between fields.
- Auto-repeat (UP/DOWN only):
  - While the button is held continuously, first step on the edge, next step after REPEAT_DELAY cycles, then one step every REPEAT_RATE cycles.
  - Release resets the repeat counter.
  - Holding UP and DOWN together: UP wins, DOWN is ignored until UP is released and DOWN re-edges.
  - Repeat steps count as button events for the timeout.
- CENTER edge in EDIT:
  - TIME_SETDATA <= working value; TIME_SET_FLAG=1 for exactly one cycle (the cycle after the edge).
  - FSM -> WAIT_EXIT.
- Abort, with no flag and TIME_SETDATA unchanged:
  - STATE != EDIT_STATE while in EDIT -> IDLE.
  - TIMEOUT cycles with no event -> WAIT_EXIT.
- WAIT_EXIT -> IDLE when STATE != EDIT_STATE. Re-entry to edit requires STATE to leave and return.
- EDITING=1 only in EDIT. EDIT_DATA holds the last working value outside EDIT.
- TIME_SETDATA is held between commits.
- RESET asserted mid-edit: immediate return to reset values; no flag.
- Width rules: field arithmetic is FIELD_W bits, unsigned. FIELD_MAX must be < 2**FIELD_W; elaboration fails otherwise.

Decomposition:
- Package rtc_pkg:
  - Button bit indices BTN_UP=4, BTN_DOWN=3, BTN_CENTER=2, BTN_LEFT=1, BTN_RIGHT=0.
  - FSM state enum {IDLE, EDIT, WAIT_EXIT}.
  - Mode code constants (EDIT_STATE=4'b0101, RUN_STATE=4'b1000).
- Sub-module btn_repeat (parameters REPEAT_DELAY, REPEAT_RATE):
  - One button level in, single-cycle step pulse out: edge plus auto-repeat.
  - Instantiated twice (UP, DOWN).
  - LEFT/RIGHT/CENTER use plain edge detect in the top.

Test Plan:
- Reset then entry: RESET=1 for 5 cycles -> all outputs 0. Then STATE=4'b0101 with CLOCK_DATA={12,34,56} -> next cycle EDITING=1, EDIT_DATA={12,34,56}, CURSOR=0.
- Cursor and wrap:
  - LEFT x3 from CURSOR=0 -> CURSOR 1,2,0. RIGHT from 0 -> 2.
  - UP on hours=23 -> hours 0. DOWN on seconds=0 -> 59. Other fields unchanged.
- Commit: edit to {13,34,56}, press CENTER -> TIME_SETDATA={13,34,56}, TIME_SET_FLAG high exactly 1 cycle, EDITING=0. STATE held at 0101 -> no re-entry; STATE=1000 then 0101 -> re-entry.
- Auto-repeat (REPEAT_DELAY=5, REPEAT_RATE=2): hold UP 12 cycles on minutes=58 -> steps at cycles 1, 6, 8, 10, 12 -> minutes 59,0,1,2,3.
- Abort: STATE leaves 0101 mid-edit -> no flag, TIME_SETDATA unchanged. TIMEOUT=20 with no buttons -> EDITING drops at cycle 20, no flag.
- Simultaneous events: CENTER+UP edge in the same cycle -> commit of the pre-UP value. RESET asserted during UP hold -> outputs 0 asynchronously.
